// File: rtl/fp_normalize_pack.sv
// fp_normalize_pack: result-side encoder for the floating-point adder.
// Takes an unnormalized sign / biased exponent / extended mantissa sum,
// normalizes it one bit per cycle, rounds to nearest-even and packs an
// IEEE-754 word. Special-case words from the operand decoder bypass the
// datapath. Single-entry: one result in flight at a time.
module fp_normalize_pack #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic [EXP_W:0]         in_exp,
  input  logic [MAN_W+4:0]       in_mant,
  input  logic                   in_spl,
  input  logic [EXP_W+MAN_W:0]   in_spl_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_result,
  output logic [3:0]             out_flags
);

  // Mantissa layout: [CRY] carry, [HID] hidden, fraction, guard, round, sticky.
  localparam int MW  = MAN_W + 5;
  localparam int XW  = EXP_W + 2;      // wide enough that +1/+1 never wraps
  localparam int HID = MAN_W + 3;
  localparam int CRY = MAN_W + 4;
  localparam logic [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_NORM  = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Flag vector order: {inexact, overflow, underflow, zero}
  localparam logic [3:0] FL_NONE  = 4'b0000;
  localparam logic [3:0] FL_ZERO  = 4'b0001;
  localparam logic [3:0] FL_FLUSH = 4'b1011;
  localparam logic [3:0] FL_OVF   = 4'b1100;

  logic [1:0]            state_reg;
  logic                  sign_reg;
  logic [XW-1:0]         exp_reg;
  logic [MW-1:0]         mant_reg;
  logic [EXP_W+MAN_W:0]  result_reg;
  logic [3:0]            flags_reg;

  logic                  rnd_inc;
  logic                  rnd_inexact;
  logic [MW-1:0]         rnd_sum;
  logic [MW-1:0]         rnd_mant;
  logic [XW-1:0]         rnd_exp;

  // Reset overrides the state so in_ready is low for the whole reset cycle.
  assign in_ready   = (state_reg == S_IDLE) && !rst;
  assign out_valid  = (state_reg == S_DONE);
  assign out_result = result_reg;
  assign out_flags  = flags_reg;

  // Round-to-nearest-even of the normalized mantissa; a carry out of the
  // significand renormalizes to 1.0 and bumps the exponent.
  always_comb begin
    rnd_inc     = mant_reg[2] & (mant_reg[1] | mant_reg[0] | mant_reg[3]);
    rnd_inexact = |mant_reg[2:0];
    rnd_sum     = mant_reg + {{(MW-4){1'b0}}, rnd_inc, 3'b000};
    rnd_mant    = rnd_sum;
    rnd_exp     = exp_reg;
    if (rnd_sum[CRY]) begin
      rnd_mant = MW'(1) << HID;
      rnd_exp  = exp_reg + XW'(1);
    end
  end

  // Control FSM plus the mantissa/exponent datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      sign_reg   <= 1'b0;
      exp_reg    <= '0;
      mant_reg   <= '0;
      result_reg <= '0;
      flags_reg  <= FL_NONE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            sign_reg <= in_sign;
            exp_reg  <= XW'(in_exp);
            mant_reg <= in_mant;
            if (in_spl) begin
              result_reg <= in_spl_result;
              flags_reg  <= FL_NONE;
              state_reg  <= S_DONE;
            end else if (in_mant == '0) begin
              result_reg <= {in_sign, {(EXP_W+MAN_W){1'b0}}};
              flags_reg  <= FL_ZERO;
              state_reg  <= S_DONE;
            end else begin
              state_reg  <= S_NORM;
            end
          end
        end
        S_NORM: begin
          if (mant_reg[CRY]) begin
            // Right shift keeps every discarded bit alive in the sticky bit.
            mant_reg  <= {1'b0, mant_reg[MW-1:2], mant_reg[1] | mant_reg[0]};
            exp_reg   <= exp_reg + XW'(1);
            state_reg <= S_ROUND;
          end else if (mant_reg[HID]) begin
            state_reg <= S_ROUND;
          end else if (exp_reg <= XW'(1)) begin
            // Would go subnormal: flush to signed zero.
            result_reg <= {sign_reg, {(EXP_W+MAN_W){1'b0}}};
            flags_reg  <= FL_FLUSH;
            state_reg  <= S_DONE;
          end else begin
            mant_reg <= {mant_reg[MW-2:0], 1'b0};
            exp_reg  <= exp_reg - XW'(1);
          end
        end
        S_ROUND: begin
          mant_reg <= rnd_mant;
          exp_reg  <= rnd_exp;
          if (rnd_exp >= EXP_MAX) begin
            result_reg <= {sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_reg  <= FL_OVF;
          end else if (rnd_exp == '0) begin
            result_reg <= {sign_reg, {(EXP_W+MAN_W){1'b0}}};
            flags_reg  <= FL_FLUSH;
          end else begin
            result_reg <= {sign_reg, rnd_exp[EXP_W-1:0], rnd_mant[MAN_W+2:3]};
            flags_reg  <= {rnd_inexact, 3'b000};
          end
          state_reg <= S_DONE;
        end
        default: begin
          if (out_ready) begin
            state_reg <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_normalize_pack.sv
// Scoreboard bench for fp_normalize_pack: a driver pushes model-predicted
// results (value, flags, latency) into a queue; a monitor pops and compares
// whenever the DUT completes an output transfer.
module tb_fp_normalize_pack;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [8:0]  in_exp = '0;
  logic [27:0] in_mant = '0;
  logic        in_spl = 1'b0;
  logic [31:0] in_spl_result = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [3:0]  out_flags;

  fp_normalize_pack dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .in_spl(in_spl), .in_spl_result(in_spl_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_txn = 0;
  int   stall_cnt = 0;
  bit   seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: locate the leading one, scale to a 24-bit significand,
  // round half-to-even on the remainder, then classify the exponent.
  function automatic void model(input logic s, input int unsigned e_in, input logic [27:0] m,
                                input logic spl, input logic [31:0] splr,
                                output logic [31:0] r, output logic [3:0] f, output int lat);
    int p;
    int e;
    longint unsigned t, sig, rem, half;
    bit inc, inexact;
    if (spl) begin
      r = splr; f = 4'b0000; lat = 1; return;
    end
    if (m == 0) begin
      r = {s, 31'b0}; f = 4'b0001; lat = 1; return;
    end
    p = 27;
    while (!m[p]) p--;
    e = int'(e_in) + p - 26;
    if (p < 26 && e < 1) begin
      r = {s, 31'b0}; f = 4'b1011;
      lat = 2 + ((e_in >= 2) ? int'(e_in) - 1 : 0);
      return;
    end
    lat = 3 + ((p < 26) ? 26 - p : 0);
    if (p == 27) begin
      t = longint'(m); sig = t >> 4; rem = t & 15; half = 8;
    end else begin
      t = longint'(m) << (26 - p); sig = t >> 3; rem = t & 7; half = 4;
    end
    inc = (rem > half) || (rem == half && sig[0]);
    inexact = (rem != 0);
    if (inc) sig++;
    if (sig == (64'd1 << 24)) begin
      sig = 64'd1 << 23; e++;
    end
    if (e >= 255) begin
      r = {s, 8'hFF, 23'b0}; f = 4'b1100;
    end else if (e == 0) begin
      r = {s, 31'b0}; f = 4'b1011;
    end else begin
      r = {s, 8'(e), 23'(sig)}; f = {inexact, 3'b000};
    end
  endfunction

  task automatic send(input logic s, input logic [8:0] e, input logic [27:0] m,
                      input logic spl, input logic [31:0] sr);
    exp_t x;
    bit ok;
    @(posedge clk); #1;
    in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m;
    in_spl = spl; in_spl_result = sr;
    model(s, e, m, spl, sr, x.res, x.flags, x.lat);
    ok = 0;
    for (int w = 0; w < 300; w++) begin
      @(negedge clk);
      if (in_ready) begin
        x.acc = cyc;
        exp_q.push_back(x);
        ok = 1;
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_sign = 1'($urandom); in_exp = 9'($urandom); in_mant = 28'($urandom);
    in_spl = 1'($urandom); in_spl_result = $urandom;
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
    end
  endtask

  // Downstream backpressure: random, or forced low for directed stalls.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (stall_cnt > 0) begin
        out_ready = 1'b0;
        stall_cnt--;
      end else begin
        out_ready = ($urandom % 4) != 0;
      end
    end
  end

  // Monitor: latency on the first valid cycle, payload every valid cycle
  // (which also proves stability while stalled), pop on transfer.
  always @(negedge clk) begin
    if (rst) begin
      seen = 0;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        if (!seen) begin
          check("latency", 32'(cyc - exp_q[0].acc), 32'(exp_q[0].lat));
          seen = 1;
        end
        check("result", out_result, exp_q[0].res);
        check("flags", 32'(out_flags), 32'(exp_q[0].flags));
        check("in_ready_in_done", 32'(in_ready), 32'd0);
        if (out_ready) begin
          $display("txn %0d: result %h flags %b latency %0d", n_txn, out_result, out_flags,
                   exp_q[0].lat);
          void'(exp_q.pop_front());
          seen = 0;
          n_txn++;
        end
      end
    end
  end

  initial begin
    logic        s;
    logic [8:0]  e;
    logic [27:0] m;
    int          sel, width;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_flags", 32'(out_flags), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Directed cases
    send(0, 9'd127, 28'h4000000, 0, 32'h0);
    send(0, 9'd127, 28'h8000000, 0, 32'h0);
    send(0, 9'd127, 28'h0800000, 0, 32'h0);
    send(0, 9'd2,   28'h1000000, 0, 32'h0);
    send(0, 9'd127, 28'h4000004, 0, 32'h0);
    send(0, 9'd127, 28'h400000C, 0, 32'h0);
    send(0, 9'd127, 28'h7FFFFFC, 0, 32'h0);
    send(1, 9'd254, 28'h8000000, 0, 32'h0);
    send(0, 9'd127, 28'h4000000, 1, 32'h7FC00000);
    send(1, 9'd127, 28'h0000000, 0, 32'h0);
    send(1, 9'd0,   28'h4000000, 0, 32'h0);
    send(0, 9'd0,   28'h0000001, 0, 32'h0);
    send(0, 9'd510, 28'hFFFFFFF, 0, 32'h0);

    // Backpressure: out_ready held low well past out_valid
    stall_cnt = 10;
    send(0, 9'd100, 28'h5555554, 0, 32'h0);

    // Reset while normalizing (k=21): result discarded, block recovers
    send(0, 9'd127, 28'h0000020, 0, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("rst_mid_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_in_ready_after", 32'(in_ready), 32'd1);
    send(1, 9'd130, 28'h6000000, 0, 32'h0);

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      sel = int'($urandom % 16);
      s = 1'($urandom);
      width = int'($urandom_range(1, 28));
      m = 28'($urandom) >> (28 - width);
      if (m == 0) m = 28'd1;
      if (sel < 6)      e = 9'($urandom_range(0, 30));
      else if (sel < 9) e = 9'($urandom_range(230, 510));
      else              e = 9'($urandom_range(0, 510));
      if (sel == 0)      send(s, e, m, 1, $urandom);
      else if (sel == 1) send(s, e, 28'd0, 0, $urandom);
      else               send(s, e, m, 0, $urandom);
      repeat ($urandom % 3) @(posedge clk);
    end

    // Drain, bounded
    for (int w = 0; w < 2000 && exp_q.size() != 0; w++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_normalize_pack.md
# fp_normalize_pack

Result-side encoder of the floating-point adder datapath, and the inverse of the operand special-case decoder. It accepts an unnormalized sign/exponent/extended-mantissa sum plus a special-case override, and normalizes it iteratively with a multi-cycle shift FSM. It then rounds to nearest-even and packs an IEEE-754 single-precision word. Input and output each use a valid/ready handshake, so it sits between the mantissa adder and the result register.

## Interface
- EXP_W, 8, exponent field width (only default verified)
- MAN_W, 23, fraction field width (only default verified)
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept; high only in IDLE
- in_sign  in  1  result sign
- in_exp  in  9  biased exponent of in_mant bit 26; range 0..510
- in_mant  in  28  [27] carry, [26] hidden, [25:3] fraction, [2] guard, [1] round, [0] sticky
- in_spl  in  1  special-case override from operand decoder
- in_spl_result  in  32  word emitted verbatim when in_spl=1
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  downstream accepts
- out_result  out  32  packed IEEE-754 word
- out_flags  out  4  {inexact, overflow, underflow, zero}

## Operation
- States: IDLE, NORM, ROUND, DONE. Reset → IDLE.
- IDLE:
  - Transfer on in_valid & in_ready; capture all inputs.
  - If in_spl=1: result = in_spl_result, flags = 0, go to DONE.
  - Else if in_mant=0: result = {in_sign, 31'b0}, zero=1, go to DONE.
  - Else go to NORM.
- NORM, one action per cycle:
  - mant[27]=1: mant = mant>>1 with sticky |= shifted-out bit, exp+1, go to ROUND.
  - Else mant[26]=1: go to ROUND.
  - Else exp≤1: flush to {sign, 31'b0}, underflow=1, zero=1, inexact=1, go to DONE.
  - Else: mant <<= 1, exp−1, stay in NORM.
- ROUND:
  - lsb = mant[3]; inc = mant[2] & (mant[1] | mant[0] | lsb).
  - inexact = |mant[2:0].
  - Add inc at bit 3. If the add carries into bit 27: mant = 1<<26 and exp+1, in the same cycle.
  - Then, if exp≥255: result = {sign, 8'hFF, 23'b0}, overflow=1, inexact=1.
  - Else if exp=0: flush to signed zero, underflow=1, zero=1, inexact=1.
  - Else: result = {sign, exp[7:0], mant[25:3]}.
  - Go to DONE.
- DONE:
  - out_valid=1; out_result and out_flags stay stable.
  - On out_ready: go to IDLE, drop out_valid.
- Subnormals are never produced; they are flushed to zero.
- in_sign is preserved on the zero, infinity and normal paths.
- Width rules: exponent arithmetic is 10-bit internally, so no wrap.

## Timing
- Reset values: state IDLE, out_valid=0, out_result=0, out_flags=0. in_ready=0 while rst is high, 1 in the first cycle after.
- Accept at cycle N:
  - Special/zero path: out_valid at N+1.
  - Normal path with k left shifts (0≤k≤26): NORM occupies N+1..N+1+k, ROUND is N+2+k, out_valid at N+3+k.
- A carry input (mant[27]=1) uses k=0, so latency is 3.
- Single-entry block: no new accept until DONE completes a transfer. The accept→out_valid latency above is a minimum; the DONE→IDLE→next-accept turnaround is ≥1 cycle.
- out_valid never drops without out_ready; its payload never changes while stalled.
- rst in any state: next cycle IDLE, out_valid=0. An in-flight result is discarded.

## Test plan
- 1.0 and 2.0:
  - in_exp=127, in_mant=1<<26 → 0x3F800000, flags 0, out_valid at N+3.
  - in_mant=1<<27 → 0x40000000 at N+3.
- Left normalize: in_exp=127, in_mant=1<<23 → 0x3E000000 at N+6 (k=3). in_exp=2, in_mant=1<<24 → flushed 0x00000000, underflow|zero|inexact.
- Rounding:
  - in_mant=(1<<26)|(1<<2) → 0x3F800000, inexact=1 (tie to even, no increment).
  - in_mant=(1<<26)|(1<<3)|(1<<2) → 0x3F800002.
  - in_mant=0x7FFFFFC, exp 127 → 0x40000000 (round carry).
- Overflow and special:
  - in_exp=254, in_mant=1<<27, sign 1 → 0xFF800000, overflow|inexact.
  - in_spl=1, in_spl_result=0x7FC00000 → 0x7FC00000 at N+1, flags 0.
- Zero: in_mant=0, in_sign=1 → 0x80000000, zero=1, at N+1.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles → out_result stable, in_ready=0 throughout.
  - Assert rst during NORM → out_valid=0 and in_ready=1 one cycle after rst deasserts; the next input is processed cleanly.
